// File: rtl/calc_pkg.sv
// Shared calculator types: BCD significand plus signed decimal exponent.
// Value = sum significand[i] * 10^(exponent - (NumDigits-1-i)); digit NumDigits-1 is the leading one.
// Consumed by number_entry (producer) and the screen driver (consumer).
package calc_pkg;

  localparam int NumDigits = 8;
  localparam int ExpWidth  = 8;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    digit_t [NumDigits-1:0]     significand;
    logic signed [ExpWidth-1:0] exponent;
  } num_t;

endpackage

// File: rtl/number_entry.sv
// Purpose: turns keypad events into a normalized num_t operand and drives the display shift override.
// Latency: one cycle from key/load edge to num_o, shift and overflow outputs.
// Backpressure: none; every key event is consumed in the cycle it is presented (or dropped).
module number_entry
  import calc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_valid_i,
  input  logic [3:0] key_i,
  input  logic       load_i,
  input  num_t       num_i,
  output num_t       num_o,
  output logic       override_shift_amount_o,
  output logic [2:0] new_shift_amount_o,
  output logic       entry_active_o,
  output logic       overflow_o
);

  localparam logic [3:0] KeyPoint = 4'd10;
  localparam logic [3:0] KeyBack  = 4'd11;
  localparam logic [3:0] KeyClear = 4'd12;
  localparam logic [3:0] FullCnt  = 4'(NumDigits);

  typedef enum logic [1:0] {
    IDLE,
    INT,
    FRAC
  } state_e;

  state_e                 state_q, state_d;
  digit_t [NumDigits-1:0] digits_q, digits_d;
  logic [3:0]             n_q, n_d;
  logic [3:0]             frac_q, frac_d;
  num_t                   num_q, num_d;
  logic                   ovr_q, ovr_d;
  logic [2:0]             shift_q, shift_d;
  logic                   ovf_q, ovf_d;
  logic                   clear_key;

  // Normalization helpers derived from the next-state digit buffer.
  logic [3:0]             lz;
  logic                   lz_found;
  logic                   all_zero;
  logic [4*NumDigits-1:0] digits_flat;
  logic [4*NumDigits-1:0] norm_sig;
  logic [ExpWidth-1:0]    norm_exp;

  // Entry FSM next state: load wins over keys, then digit/point/backspace/clear rules.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    n_d       = n_q;
    frac_d    = frac_q;
    ovf_d     = 1'b0;
    clear_key = 1'b0;
    if (load_i) begin
      state_d  = IDLE;
      digits_d = '0;
      n_d      = 4'd0;
      frac_d   = 4'd0;
    end else if (key_valid_i) begin
      if (key_i <= 4'd9) begin
        if (state_q == IDLE) begin
          digits_d    = '0;
          digits_d[0] = key_i;
          n_d         = (key_i != 4'd0) ? 4'd1 : 4'd0;
          frac_d      = 4'd0;
          state_d     = INT;
        end else if (state_q == INT && n_q == 4'd0 && key_i == 4'd0) begin
          // Leading zero of the integer part carries no information.
          n_d = n_q;
        end else if (n_q < FullCnt) begin
          digits_d = {digits_q[NumDigits-2:0], key_i};
          n_d      = n_q + 4'd1;
          if (state_q == FRAC) frac_d = frac_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        case (key_i)
          KeyPoint: begin
            if (state_q == IDLE) begin
              digits_d = '0;
              n_d      = 4'd0;
              frac_d   = 4'd0;
              state_d  = FRAC;
            end else if (state_q == INT) begin
              state_d = FRAC;
            end
          end
          KeyBack: begin
            if (state_q == FRAC && frac_q == 4'd0) begin
              state_d = INT;
            end else if ((state_q == FRAC) || (state_q == INT && n_q != 4'd0)) begin
              digits_d = {4'd0, digits_q[NumDigits-1:1]};
              n_d      = n_q - 4'd1;
              if (state_q == FRAC) frac_d = frac_q - 4'd1;
            end
          end
          KeyClear: begin
            clear_key = 1'b1;
            state_d   = IDLE;
            digits_d  = '0;
            n_d       = 4'd0;
            frac_d    = 4'd0;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  // Leading-zero count and left-justified significand of the buffer being entered.
  always_comb begin
    lz          = 4'd0;
    lz_found    = 1'b0;
    digits_flat = digits_d;
    for (int i = NumDigits - 1; i >= 0; i--) begin
      if (!lz_found && digits_d[i] == 4'd0) lz = lz + 4'd1;
      else lz_found = 1'b1;
    end
    all_zero = (lz == FullCnt);
    norm_sig = digits_flat << {lz, 2'b00};
    norm_exp = ExpWidth'(NumDigits - 1) - ExpWidth'(lz) - ExpWidth'(frac_d);
  end

  // Output next state: live normalized value while entering, otherwise loaded/cleared/held value.
  always_comb begin
    num_d   = num_q;
    shift_d = shift_q;
    ovr_d   = 1'b0;
    if (state_d != IDLE) begin
      ovr_d = 1'b1;
      if (all_zero) begin
        num_d   = '0;
        shift_d = 3'(NumDigits - 1);
      end else begin
        num_d.significand = norm_sig;
        num_d.exponent    = norm_exp;
        shift_d           = lz[2:0];
      end
    end else if (load_i) begin
      num_d   = num_i;
      shift_d = 3'd0;
    end else if (clear_key) begin
      num_d = '0;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      digits_q <= '0;
      n_q      <= 4'd0;
      frac_q   <= 4'd0;
      num_q    <= '0;
      ovr_q    <= 1'b0;
      shift_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      n_q      <= n_d;
      frac_q   <= frac_d;
      num_q    <= num_d;
      ovr_q    <= ovr_d;
      shift_q  <= shift_d;
      ovf_q    <= ovf_d;
    end
  end

  assign num_o                   = num_q;
  assign override_shift_amount_o = ovr_q;
  assign new_shift_amount_o      = shift_q;
  assign entry_active_o          = (state_q != IDLE);
  assign overflow_o              = ovf_q;

endmodule

// File: tb/tb_number_entry.sv
// Self-checking bench for number_entry: directed keypad scenarios plus randomized keys.
// Expected values come from a typed-digit-list model evaluated with integer arithmetic.
module tb_number_entry;
  import calc_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       key_valid_i;
  logic [3:0] key_i;
  logic       load_i;
  num_t       num_i;
  num_t       num_o;
  logic       override_shift_amount_o;
  logic [2:0] new_shift_amount_o;
  logic       entry_active_o;
  logic       overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 idle, 1 integer entry, 2 fraction entry; digits typed in order.
  int         m_mode;
  int         m_q[$];
  int         m_frac;
  num_t       m_num;
  logic [2:0] m_shift;
  bit         m_ovr;
  bit         m_ovf;

  localparam num_t ZERO = '0;

  number_entry dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .key_valid_i             (key_valid_i),
    .key_i                   (key_i),
    .load_i                  (load_i),
    .num_i                   (num_i),
    .num_o                   (num_o),
    .override_shift_amount_o (override_shift_amount_o),
    .new_shift_amount_o      (new_shift_amount_o),
    .entry_active_o          (entry_active_o),
    .overflow_o              (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic num_t mk_num(input longint v, input int e);
    num_t r;
    r = '0;
    for (int i = 0; i < NumDigits; i++) begin
      r.significand[i] = 4'(v % 10);
      v = v / 10;
    end
    r.exponent = ExpWidth'(e);
    return r;
  endfunction

  // Recompute displayed value from the typed digits as a plain decimal integer.
  task automatic model_eval();
    longint v = 0;
    longint t;
    int len = 0;
    int s;
    foreach (m_q[i]) v = v * 10 + m_q[i];
    if (v == 0) begin
      m_num   = ZERO;
      m_shift = 3'd7;
    end else begin
      t = v;
      while (t != 0) begin
        t = t / 10;
        len++;
      end
      s = NumDigits - len;
      for (int i = 0; i < s; i++) v = v * 10;
      m_num   = mk_num(v, NumDigits - 1 - s - m_frac);
      m_shift = 3'(s);
    end
  endtask

  task automatic model_apply(input bit kv, input int k, input bit ld, input num_t ln, input bit rst);
    m_ovf = 1'b0;
    if (rst) begin
      m_mode = 0; m_q.delete(); m_frac = 0; m_num = ZERO; m_shift = 3'd0;
    end else if (ld) begin
      m_mode = 0; m_q.delete(); m_frac = 0; m_num = ln;
    end else if (kv) begin
      if (k <= 9) begin
        if (m_mode == 0) begin
          m_q.delete();
          if (k != 0) m_q.push_back(k);
          m_frac = 0; m_mode = 1;
        end else if (m_mode == 1 && m_q.size() == 0 && k == 0) begin
          m_frac = m_frac;
        end else if (m_q.size() < NumDigits) begin
          m_q.push_back(k);
          if (m_mode == 2) m_frac++;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (k == 10) begin
        if (m_mode == 0) begin
          m_q.delete(); m_frac = 0; m_mode = 2;
        end else if (m_mode == 1) begin
          m_mode = 2;
        end
      end else if (k == 11) begin
        if (m_mode == 2 && m_frac == 0) m_mode = 1;
        else if (m_mode == 2) begin
          void'(m_q.pop_back()); m_frac--;
        end else if (m_mode == 1 && m_q.size() > 0) void'(m_q.pop_back());
      end else if (k == 12) begin
        m_mode = 0; m_q.delete(); m_frac = 0; m_num = ZERO;
      end
    end
    m_ovr = (m_mode != 0);
    if (m_mode != 0) model_eval();
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input bit kv, input int k, input bit ld, input num_t ln, input bit rst);
    @(negedge clk_i);
    key_valid_i = kv;
    key_i       = 4'(k);
    load_i      = ld;
    num_i       = ln;
    rst_ni      = !rst;
    @(posedge clk_i);
    #1;
    key_valid_i = 1'b0;
    load_i      = 1'b0;
    rst_ni      = 1'b1;
    model_apply(kv, k, ld, ln, rst);
  endtask

  task automatic key(input int k);
    step(1'b1, k, 1'b0, ZERO, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 0, 1'b0, ZERO, 1'b1);
    n_checks++;
    if (num_o !== ZERO || override_shift_amount_o !== 1'b0 || new_shift_amount_o !== 3'd0 ||
        entry_active_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: num=%h ovr=%b shift=%0d act=%b ovf=%b, want all zero",
               num_o, override_shift_amount_o, new_shift_amount_o, entry_active_o, overflow_o);
    end
  endtask

  task automatic test_decimal();
    key(12); key(1); key(2); key(10); key(5);
    n_checks++;
    if (num_o !== mk_num(64'd12500000, 1) || new_shift_amount_o !== 3'd5 ||
        override_shift_amount_o !== 1'b1 || entry_active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL decimal_12.5: num=%h shift=%0d ovr=%b act=%b, want %h shift 5 ovr 1 act 1",
               num_o, new_shift_amount_o, override_shift_amount_o, entry_active_o, mk_num(64'd12500000, 1));
    end
    n_checks++;
    if (num_o !== m_num) begin
      n_fail++;
      $display("FAIL decimal_model: num=%h want %h", num_o, m_num);
    end
  endtask

  task automatic test_leading_zero();
    key(12); key(0); key(0); key(7);
    n_checks++;
    if (num_o !== mk_num(64'd70000000, 0) || new_shift_amount_o !== 3'd7) begin
      n_fail++;
      $display("FAIL leading_zero_7: num=%h shift=%0d, want 70000000/0 shift 7", num_o, new_shift_amount_o);
    end
    key(10); key(0);
    n_checks++;
    if (num_o !== mk_num(64'd70000000, 0) || new_shift_amount_o !== 3'd6) begin
      n_fail++;
      $display("FAIL trailing_zero_7.0: num=%h shift=%0d, want 70000000/0 shift 6", num_o, new_shift_amount_o);
    end
  endtask

  task automatic test_overflow();
    key(12);
    for (int d = 1; d <= 8; d++) key(d);
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_early: ovf=%b want 0", overflow_o);
    end
    key(9);
    n_checks++;
    if (overflow_o !== 1'b1 || num_o !== mk_num(64'd12345678, 7)) begin
      n_fail++;
      $display("FAIL overflow_pulse: ovf=%b num=%h, want ovf 1 num %h", overflow_o, num_o, mk_num(64'd12345678, 7));
    end
    step(1'b0, 0, 1'b0, ZERO, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b0 || num_o !== mk_num(64'd12345678, 7)) begin
      n_fail++;
      $display("FAIL overflow_one_cycle: ovf=%b num=%h, want ovf 0", overflow_o, num_o);
    end
  endtask

  task automatic test_backspace();
    key(12); key(4); key(10); key(2);
    key(11);
    n_checks++;
    if (num_o !== mk_num(64'd40000000, 0) || entry_active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL backspace_4.: num=%h act=%b, want 40000000/0 active", num_o, entry_active_o);
    end
    key(11);
    n_checks++;
    if (num_o !== mk_num(64'd40000000, 0) || override_shift_amount_o !== 1'b1) begin
      n_fail++;
      $display("FAIL backspace_int4: num=%h ovr=%b, want 40000000/0 ovr 1", num_o, override_shift_amount_o);
    end
    key(11);
    n_checks++;
    if (num_o !== ZERO || new_shift_amount_o !== 3'd7) begin
      n_fail++;
      $display("FAIL backspace_empty: num=%h shift=%0d, want 0 shift 7", num_o, new_shift_amount_o);
    end
    key(11);
    n_checks++;
    if (num_o !== ZERO || entry_active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL backspace_extra: num=%h act=%b, want 0 active", num_o, entry_active_o);
    end
  endtask

  task automatic test_load();
    num_t ln;
    ln = mk_num(64'd30000000, -2);
    step(1'b1, 5, 1'b1, ln, 1'b0);
    n_checks++;
    if (num_o !== ln || override_shift_amount_o !== 1'b0 || entry_active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load: num=%h ovr=%b act=%b, want %h ovr 0 act 0",
               num_o, override_shift_amount_o, entry_active_o, ln);
    end
    key(9);
    n_checks++;
    if (num_o !== mk_num(64'd90000000, 0) || entry_active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_then_9: num=%h act=%b, want 90000000/0 active", num_o, entry_active_o);
    end
  endtask

  task automatic test_reset_mid();
    key(12); key(1); key(2);
    step(1'b0, 0, 1'b0, ZERO, 1'b1);
    n_checks++;
    if (num_o !== ZERO || override_shift_amount_o !== 1'b0 || new_shift_amount_o !== 3'd0 ||
        entry_active_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: num=%h ovr=%b shift=%0d act=%b ovf=%b, want all zero",
               num_o, override_shift_amount_o, new_shift_amount_o, entry_active_o, overflow_o);
    end
    key(1); key(2); key(12);
    n_checks++;
    if (num_o !== ZERO || override_shift_amount_o !== 1'b0 || entry_active_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_mid: num=%h ovr=%b act=%b ovf=%b, want zero/idle",
               num_o, override_shift_amount_o, entry_active_o, overflow_o);
    end
  endtask

  task automatic test_random();
    num_t ln;
    bit   kv, ld, rs;
    int   k;
    for (int c = 0; c < 600; c++) begin
      kv = ($urandom_range(0, 9) < 7);
      k  = (c % 3 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 11);
      ld = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 79) == 0);
      ln = '0;
      for (int i = 0; i < NumDigits; i++) ln.significand[i] = 4'($urandom_range(0, 9));
      ln.exponent = ExpWidth'($urandom_range(0, 255));
      step(kv, k, ld, ln, rs);
      n_checks++;
      if (num_o !== m_num || override_shift_amount_o !== m_ovr || entry_active_o !== m_ovr ||
          overflow_o !== m_ovf || (m_ovr && new_shift_amount_o !== m_shift)) begin
        n_fail++;
        $display("FAIL random_c%0d: num=%h ovr=%b act=%b ovf=%b shift=%0d, want num=%h ovr=%b ovf=%b shift=%0d",
                 c, num_o, override_shift_amount_o, entry_active_o, overflow_o, new_shift_amount_o,
                 m_num, m_ovr, m_ovf, m_shift);
      end
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    key_valid_i = 1'b0;
    key_i       = 4'd0;
    load_i      = 1'b0;
    num_i       = '0;
    test_reset();
    test_decimal();
    test_leading_zero();
    test_overflow();
    test_backspace();
    test_load();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/number_entry.md
Name: number_entry

Overview:
Keypad-to-number front end of the calculator, the input-side counterpart of the screen driver. It accepts single-cycle key events (digits, decimal point, backspace, clear) and builds a normalized calc_pkg::num_t holding the operand the user is typing. While entry is in progress it drives the screen driver's shift override, so trailing fractional zeros (e.g. "1.50") stay visible. An ALU result can be loaded to replace the displayed number.

Parameters:
- none: digit count is calc_pkg::NumDigits (8).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low.
- key_valid_i  input  1  one-cycle key event strobe; no backpressure.
- key_i  input  4  key code, sampled with key_valid_i: 0-9 digit, 10 decimal point, 11 backspace, 12 clear, 13-15 ignored.
- load_i  input  1  load num_i as the displayed value.
- num_i  input  calc_pkg::num_t  result to load.
- num_o  output  calc_pkg::num_t  current number, registered.
- override_shift_amount_o  output  1  high while in INT or FRAC.
- new_shift_amount_o  output  3  display shift while entering.
- entry_active_o  output  1  state != IDLE.
- overflow_o  output  1  one-cycle pulse when a digit is dropped because the buffer is full.

Behaviour:
- num_t value = sum over i of significand[i]·10^(exponent−(NumDigits−1−i)), so significand[NumDigits−1] has weight 10^exponent. exponent is signed.
- Internal state:
  - buf: NumDigits BCD digits, right-aligned; new digits shift in at index 0.
  - n: significant digit count, 0..NumDigits.
  - frac: fractional digit count, 0..n.
  - FSM: IDLE, INT, FRAC.
- Reset (rst_ni=0 at an edge), also mid-entry: state IDLE, buf=0, n=0, frac=0, num_o all zero (significand 0, exponent 0), override 0, new_shift 0, overflow 0.
- Priority per cycle: reset > load_i > key. A key in the same cycle as load_i is dropped.
- load_i: num_o<=num_i; state IDLE; buf, n, frac cleared; override 0.
- Digit d:
  - IDLE: buf=d, frac=0, go INT. n=1 if d≠0, else n=0.
  - INT with n=0 and d=0: no change (leading zero).
  - INT or FRAC with n<NumDigits: shift d in. n++ unless (state INT and n=0 and d=0). In FRAC also frac++.
  - n=NumDigits: digit dropped, overflow_o pulses high the next cycle.
- Point:
  - IDLE: buf=0, n=0, frac=0, go FRAC.
  - INT: go FRAC.
  - FRAC: ignored.
- Backspace:
  - IDLE: ignored.
  - FRAC with frac=0: go INT.
  - FRAC with frac>0: shift buf right (0 into top), n--, frac--.
  - INT with n>0: shift right, n--.
  - INT with n=0: no change.
- Clear (any state): same as reset except the 3-bit output value is not re-reset mid-pulse; state IDLE, num_o zero, override 0.
- num_o (INT/FRAC), registered one cycle after the key edge (latency 1):
  - s = leading-zero count of buf.
  - significand = buf shifted left by s.
  - exponent = (NumDigits−1) − s − frac.
  - buf all zero: significand 0, exponent 0.
- new_shift_amount_o = s; when buf is all zero it is NumDigits−1. Registered with num_o. Override is high in INT/FRAC only.
- In IDLE after load: num_o holds the loaded value and override is 0.
- Arithmetic: s and n are 4 bits internally (value 8 is reachable); exponent is computed at exponent width with sign extension.

Test Plan:
- Keys 1,2,.,5 → num_o significand digits [7..0]=1,2,5,0,0,0,0,0, exponent 1, new_shift 5, override 1, entry_active 1.
- Keys 0,0,7 → n=1, significand 7000_0000, exponent 0, shift 7. Then keys .,0 → significand 7000_0000, exponent 0, frac 1, shift 6 (display "7.0").
- Nine digits 1..9 → first eight accepted (significand 1234_5678, exponent 7); the ninth raises overflow_o for exactly one cycle; num_o unchanged.
- Keys 4,.,2 then backspace ×3 → 4. (FRAC, frac 0) → INT 4 → INT 0, significand 0, exponent 0; a further backspace causes no change.
- load_i=1 with num_i={significand 3000_0000, exponent −2} in the same cycle as key 5 → num_o = num_i, state IDLE, override 0, key ignored. Next key 9 → significand 9000_0000, exponent 0.
- rst_ni low for one edge mid-entry (after 1,2) → all outputs zero the following cycle, state IDLE. Clear key gives the same result.
